// File: rtl/baby_serial_sub_seq_if.sv
// -----------------------------------------------------------------------------
// baby_serial_sub_seq_if
// Request/result bundle between the Baby control unit and the bit-serial
// subtract sequencer.
//
//   start  : request strobe (control unit -> sequencer)
//   op     : 0 = SUB (a - b), 1 = LDN (0 - b)
//   a, b   : minuend / subtrahend, captured when the request is accepted
//   busy   : sequencer is stepping bits
//   done   : one-cycle completion pulse, result valid
//   result : last completed difference
//   neg    : sign bit of result
//   zero   : result == 0
//   sbit   : difference bit produced this cycle (meaningful while busy)
//   borrow : final borrow of last operation (only with BORROW_OUT_EN)
//
// Modports: master = requester (control unit / bench), slave = sequencer.
// -----------------------------------------------------------------------------
interface baby_serial_sub_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             neg;
    logic             zero;
    logic             sbit;
`ifdef BORROW_OUT_EN
    logic             borrow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, neg, zero, sbit, borrow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, neg, zero, sbit, borrow
    );
`else
    modport master (
        output start, op, a, b,
        input  busy, done, result, neg, zero, sbit
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, neg, zero, sbit
    );
`endif
endinterface

// File: rtl/baby_serial_sub_seq.sv
// -----------------------------------------------------------------------------
// baby_serial_sub_seq
// Bit-serial subtract sequencer for the Baby arithmetic unit. Operands are
// captured on an accepted start, then stepped LSB-first through one
// full-subtractor bit per clock with the borrow held in a flip-flop. After
// WIDTH bits the parallel result, sign and zero flags are published together
// with a one-cycle done pulse.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; dominates a simultaneous start
//   bus   : baby_serial_sub_seq_if.slave (start/op/a/b in,
//           busy/done/result/neg/zero/sbit[/borrow] out)
//
// Optional feature macro: BORROW_OUT_EN -- adds the registered final-borrow
// output (1 when unsigned a < b for SUB, or b != 0 for LDN).
// -----------------------------------------------------------------------------
module baby_serial_sub_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic                 clk,
    input logic                 reset,
    baby_serial_sub_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             last_bit;
    logic [CNT_W-1:0] cnt;
    logic             brw;
    logic             brw_nxt;
    logic             d_bit;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] result_q;
    logic             neg_q;
    logic             zero_q;
`ifdef BORROW_OUT_EN
    logic             borrow_q;
`endif

    function automatic logic sub_diff(input logic a_bit, input logic b_bit,
                                      input logic b_in);
        return a_bit ^ b_bit ^ b_in;
    endfunction

    function automatic logic sub_borrow(input logic a_bit, input logic b_bit,
                                        input logic b_in);
        return (~a_bit & b_bit) | (~(a_bit ^ b_bit) & b_in);
    endfunction

    // Current bit slice: the full subtractor looks at the LSBs of the
    // operand shift registers and the stored borrow.
    assign d_bit    = sub_diff(sa[0], sb[0], brw);
    assign brw_nxt  = sub_borrow(sa[0], sb[0], brw);
    assign sr_nxt   = {d_bit, sr[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // start is deliberately not looked at here: no queueing
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state: bit counter, borrow flip-flop and published flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            brw      <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b1;
`ifdef BORROW_OUT_EN
            borrow_q <= 1'b0;
`endif
        end else if (accept) begin
            cnt <= '0;
            brw <= 1'b0;
        end else if (state == ST_SHIFT) begin
            cnt <= cnt + CNT_W'(1);
            brw <= brw_nxt;
            if (last_bit) begin
                result_q <= sr_nxt;
                neg_q    <= sr_nxt[WIDTH-1];
                zero_q   <= (sr_nxt == '0);
`ifdef BORROW_OUT_EN
                borrow_q <= brw_nxt;
`endif
            end
        end
    end

    // Data shift registers carry no reset: every bit is rewritten by the
    // next accepted operation before it is observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            sa <= bus.op ? '0 : bus.a;
            sb <= bus.b;
        end else if (state == ST_SHIFT) begin
            sa <= {1'b0, sa[WIDTH-1:1]};
            sb <= {1'b0, sb[WIDTH-1:1]};
            sr <= sr_nxt;
        end
    end

    assign bus.busy   = (state == ST_SHIFT);
    assign bus.done   = (state == ST_DONE);
    assign bus.sbit   = (state == ST_SHIFT) ? d_bit : 1'b0;
    assign bus.result = result_q;
    assign bus.neg    = neg_q;
    assign bus.zero   = zero_q;
`ifdef BORROW_OUT_EN
    assign bus.borrow = borrow_q;
`endif

endmodule

// File: tb/tb_baby_serial_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_baby_serial_sub_seq
// Self-checking bench for baby_serial_sub_seq. Expected results come from a
// plain-arithmetic model: result = (op ? 0 : a) - b modulo 2^W, bit i of that
// value is the serial bit seen i cycles after acceptance.
// -----------------------------------------------------------------------------
module tb_baby_serial_sub_seq;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    baby_serial_sub_seq_if #(.WIDTH(W)) bus ();

    baby_serial_sub_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs,
                        input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete operation from idle; operand inputs are scrambled while
    // shifting, and optionally start is pulsed mid-operation.
    task automatic run_op(input logic op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, input bit glitch);
        logic [W-1:0] exp_r;
        logic         exp_b;
        exp_r = (op_i ? {W{1'b0}} : a_i) - b_i;
        exp_b = op_i ? (b_i != 0) : (a_i < b_i);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        tick();
        for (int i = 0; i < W; i++) begin
            chk1("busy", bus.busy, 1'b1);
            chk1("done_early", bus.done, 1'b0);
            chk1($sformatf("sbit[%0d]", i), bus.sbit, exp_r[i]);
            bus.a     = $urandom;
            bus.b     = $urandom;
            bus.op    = 1'($urandom);
            bus.start = glitch && (i == 5 || i == 20);
            tick();
        end
        bus.start = 1'b0;
        chk1("done", bus.done, 1'b1);
        chk1("busy_end", bus.busy, 1'b0);
        chk1("sbit_idle", bus.sbit, 1'b0);
        chkw("result", bus.result, exp_r);
        chk1("neg", bus.neg, exp_r[W-1]);
        chk1("zero", bus.zero, exp_r == 0);
`ifdef BORROW_OUT_EN
        chk1("borrow", bus.borrow, exp_b);
`else
        if (exp_b === 1'bx) $display("[TB] unexpected model state");
`endif
        tick();
        chk1("done_fall", bus.done, 1'b0);
        chk1("busy_idle", bus.busy, 1'b0);
        chkw("result_hold", bus.result, exp_r);
    endtask

    initial begin
        int first_done;
        int second_done;
        int done_cnt;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic         z2;

        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chkw("rst_result", bus.result, '0);
        chk1("rst_neg", bus.neg, 1'b0);
        chk1("rst_zero", bus.zero, 1'b1);
        chk1("rst_sbit", bus.sbit, 1'b0);
`ifdef BORROW_OUT_EN
        chk1("rst_borrow", bus.borrow, 1'b0);
`endif
        tick();

        // directed cases
        run_op(1'b0, 32'd5, 32'd3, 1'b0);
        run_op(1'b0, 32'd3, 32'd5, 1'b0);

        // reset mid-shift with simultaneous start
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        chk1("mrst_busy", bus.busy, 1'b0);
        chk1("mrst_done", bus.done, 1'b0);
        chkw("mrst_result", bus.result, '0);
        chk1("mrst_zero", bus.zero, 1'b1);
        chk1("mrst_neg", bus.neg, 1'b0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) done_cnt++;
            tick();
        end
        chki("mrst_no_done", done_cnt, 0);

        run_op(1'b1, 32'h1234_5678, 32'd1, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(1'b0, $urandom, $urandom, 1'b1);
        run_op(1'b1, $urandom, 32'd0, 1'b0);

        // random operations
        for (int k = 0; k < 8; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = (k == 3) ? ra : $urandom;
            run_op(1'($urandom), ra, rb, 1'($urandom));
        end

        // back-to-back with start held high
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'd10;
        bus.b     = 32'd4;
        tick();
        bus.a       = 32'd7;
        bus.b       = 32'd7;
        first_done  = -1;
        second_done = -1;
        r1          = '1;
        r2          = '1;
        z2          = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (bus.done) begin
                if (first_done < 0) begin
                    first_done = c;
                    r1         = bus.result;
                end else if (second_done < 0) begin
                    second_done = c;
                    r2          = bus.result;
                    z2          = bus.zero;
                end
            end
        end
        bus.start = 1'b0;
        chki("b2b_latency", first_done, W);
        chki("b2b_spacing", second_done - first_done, W + 1);
        chkw("b2b_result1", r1, 32'd6);
        chkw("b2b_result2", r2, 32'd0);
        chk1("b2b_zero2", z2, 1'b1);
        repeat (W + 4) tick();
        chk1("b2b_idle", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
